// File: rtl/ysyx_25060170_pkg.sv
// Shared MDU definitions: ALU opcodes, FSM state encoding, and opcode decode.
package ysyx_25060170_pkg;
  localparam int XLEN = 32;

  localparam logic [3:0] ALU_MUL = 4'd2;
  localparam logic [3:0] ALU_DIV = 4'd3;
  localparam logic [3:0] ALU_REM = 4'd10;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_DIV = 2'd1,
    OP_REM = 2'd2
  } mdu_op_e;

  // Unknown opcodes fall back to multiply so the FSM always has a defined path.
  function automatic mdu_op_e decode_op(input logic [3:0] aluop);
    case (aluop)
      ALU_DIV: return OP_DIV;
      ALU_REM: return OP_REM;
      default: return OP_MUL;
    endcase
  endfunction
endpackage

// File: rtl/ysyx_25060170_mdu_ctrl_if.sv
// Issue/writeback handshake bundle between IDU, MDU and WBU.
interface ysyx_25060170_mdu_ctrl_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      ALUop;
  logic [XLEN-1:0] exu_op_1;
  logic [XLEN-1:0] exu_op_2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] mdu_res;

  modport master (
    output in_valid, ALUop, exu_op_1, exu_op_2, out_ready,
    input  in_ready, out_valid, mdu_res
  );

  modport slave (
    input  in_valid, ALUop, exu_op_1, exu_op_2, out_ready,
    output in_ready, out_valid, mdu_res
  );
endinterface

// File: rtl/ysyx_25060170_mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply or restoring-divide step.
// Registers are shared: a = acc/rem, b = multiplicand/quot, c = multiplier/divisor.
module ysyx_25060170_mdu_step #(
  parameter int XLEN = 32
) (
  input  logic            is_mul,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] c,
  output logic [XLEN-1:0] a_nxt,
  output logic [XLEN-1:0] b_nxt,
  output logic [XLEN-1:0] c_nxt
);
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    rem_sh = {a, b[XLEN-1]};
    diff   = rem_sh - {1'b0, c};
    a_nxt  = a;
    b_nxt  = b;
    c_nxt  = c;
    if (is_mul) begin
      a_nxt = a + (c[0] ? b : '0);
      b_nxt = b << 1;
      c_nxt = c >> 1;
    end else if (!diff[XLEN]) begin
      a_nxt = diff[XLEN-1:0];
      b_nxt = {b[XLEN-2:0], 1'b1};
    end else begin
      a_nxt = rem_sh[XLEN-1:0];
      b_nxt = {b[XLEN-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/ysyx_25060170_mdu_ctrl.sv
// Multi-cycle unsigned mul/div/rem sequencer; stalls issue while an op is in flight.
module ysyx_25060170_mdu_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  ysyx_25060170_mdu_ctrl_if.slave  bus
);
  import ysyx_25060170_pkg::*;

  mdu_state_e      state;
  mdu_op_e         op;
  mdu_op_e         in_op;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] a, b, c;
  logic [XLEN-1:0] a_nxt, b_nxt, c_nxt;
  logic            last;
  logic            in_div0;

  assign in_op   = decode_op(bus.ALUop);
  assign last    = (cnt == CNT_W'(XLEN-1));
  assign in_div0 = (in_op != OP_MUL) && (bus.exu_op_2 == '0);

  ysyx_25060170_mdu_step #(.XLEN(XLEN)) u_step (
    .is_mul (op == OP_MUL),
    .a      (a),
    .b      (b),
    .c      (c),
    .a_nxt  (a_nxt),
    .b_nxt  (b_nxt),
    .c_nxt  (c_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= MDU_IDLE;
      op            <= OP_MUL;
      cnt           <= '0;
      a             <= '0;
      b             <= '0;
      c             <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.mdu_res   <= '0;
    end else if (flush) begin
      state         <= MDU_IDLE;
      cnt           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (bus.in_valid) begin
            op           <= in_op;
            cnt          <= '0;
            bus.in_ready <= 1'b0;
            // Divide by zero: quotient all-ones, remainder = dividend, no iterations.
            if (in_div0) begin
              a     <= bus.exu_op_1;
              b     <= '1;
              c     <= '0;
              state <= MDU_DONE;
            end else begin
              a     <= '0;
              b     <= bus.exu_op_1;
              c     <= bus.exu_op_2;
              state <= MDU_BUSY;
            end
          end
        end
        MDU_BUSY: begin
          a   <= a_nxt;
          b   <= b_nxt;
          c   <= c_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            state         <= MDU_DONE;
            bus.out_valid <= 1'b1;
            bus.mdu_res   <= (op == OP_DIV) ? b_nxt : a_nxt;
          end
        end
        MDU_DONE: begin
          // The divide-by-zero shortcut arrives here with out_valid still low.
          if (!bus.out_valid) begin
            bus.out_valid <= 1'b1;
            bus.mdu_res   <= (op == OP_DIV) ? b : a;
          end else if (bus.out_ready) begin
            state         <= MDU_IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: begin
          state         <= MDU_IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25060170_mdu_ctrl.sv
// Self-checking bench for the MDU sequencer: directed cases plus random ops vs. a reference model.
module tb_ysyx_25060170_mdu_ctrl;
  import ysyx_25060170_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  ysyx_25060170_mdu_ctrl_if #(.XLEN(32)) bus ();

  ysyx_25060170_mdu_ctrl #(.XLEN(32), .CNT_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    case (op)
      ALU_DIV: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      ALU_REM: return (y == 0) ? x : x % y;
      default: begin
        p = {32'b0, x} * {32'b0, y};
        return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] y);
    return (op != ALU_MUL && y == 0) ? 1 : 32;
  endfunction

  always @(posedge clk)
    if (!rst && !flush && bus.in_valid && bus.in_ready)
      assert (bus.ALUop == ALU_MUL || bus.ALUop == ALU_DIV || bus.ALUop == ALU_REM)
        else $error("illegal ALUop %0d accepted", bus.ALUop);

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Issue one op, measure latency, optionally hold off the result for bp cycles.
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input int bp, input string tag);
    int t, lat;
    logic [31:0] held;
    logic stable;
    t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.ALUop    = op;
    bus.exu_op_1 = x;
    bus.exu_op_2 = y;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.exu_op_1 = $urandom;
    bus.exu_op_2 = $urandom;
    chk({tag, "_busy_rdy"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(ref_lat(op, y)));
    chk({tag, "_res"}, bus.mdu_res, ref_res(op, x, y));
    held   = bus.mdu_res;
    stable = 1'b1;
    for (int i = 0; i < bp; i++) begin
      bus.in_valid = 1'b1;
      bus.ALUop    = ALU_MUL;
      bus.exu_op_1 = 32'd3;
      bus.exu_op_2 = 32'd5;
      @(negedge clk);
      if (!bus.out_valid || bus.mdu_res !== held || bus.in_ready) stable = 1'b0;
    end
    if (bp > 0) chk({tag, "_hold"}, 32'(stable), 32'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_idle_rdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  // Start a mul, abort it with flush or reset during iteration 10, verify no result appears.
  task automatic abort_op(input bit use_rst, input string tag);
    int ov;
    bus.in_valid = 1'b1;
    bus.ALUop    = ALU_MUL;
    bus.exu_op_1 = $urandom;
    bus.exu_op_2 = $urandom;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else         flush = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    flush = 1'b0;
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_ov"}, 32'(bus.out_valid), 32'd0);
    ov = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) ov++;
    end
    chk({tag, "_no_ov"}, 32'(ov), 32'd0);
    run_op(ALU_MUL, 32'd3, 32'd3, 0, {tag, "_mul3x3"});
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] rx, ry;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.ALUop     = ALU_MUL;
    bus.exu_op_1  = '0;
    bus.exu_op_2  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mdu_res", bus.mdu_res, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(ALU_MUL, 32'd7,          32'd6,       0, "mul_7x6");
    run_op(ALU_MUL, 32'hFFFF_FFFF,  32'd2,       0, "mul_ffx2");
    run_op(ALU_MUL, 32'h0001_0000,  32'h1_0000,  0, "mul_wrap");
    run_op(ALU_DIV, 32'd100,        32'd7,       0, "div_100_7");
    run_op(ALU_REM, 32'd100,        32'd7,       0, "rem_100_7");
    run_op(ALU_DIV, 32'hFFFF_FFFF,  32'd1,       0, "div_ff_1");
    run_op(ALU_DIV, 32'd5,          32'd0,       0, "div_by0");
    run_op(ALU_REM, 32'd5,          32'd0,       0, "rem_by0");
    run_op(ALU_DIV, 32'd1234567,    32'd89,     10, "bp_div");
    run_op(ALU_MUL, 32'd11,         32'd13,      0, "after_bp");
    abort_op(1'b0, "flush");
    abort_op(1'b1, "reset");

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0:       rop = ALU_MUL;
        1:       rop = ALU_DIV;
        default: rop = ALU_REM;
      endcase
      rx = $urandom;
      case ($urandom_range(0, 5))
        0:       ry = 32'd0;
        1, 2:    ry = 32'($urandom_range(1, 255));
        default: ry = $urandom;
      endcase
      run_op(rop, rx, ry, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
